mmio_io_ctrl: RTL and testbench

//   Memory-mapped I/O controller for the RISC-V core's 0x8000_00xx window.

---
 rtl/mmio_io_ctrl_if.sv | 32 +++
 rtl/mmio_io_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_mmio_io_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_io_ctrl_if.sv
// Memory-stage bus, instruction/branch events and UART byte streams of mmio_io_ctrl.
// The core-side master drives requests; the controller is the slave.
interface mmio_io_ctrl_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] rdata;
  logic        inst_retired;
  logic        br_valid;
  logic        br_taken;
  // Both byte streams move one byte on each clock edge where valid and ready are both 1.
  // valid must not depend on ready, and the data is stable whenever valid is high.
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output addr, wdata, wr_en, rd_en, inst_retired, br_valid, br_taken,
    output rx_data, rx_valid, tx_ready,
    input  rdata, rx_ready, tx_data, tx_valid
  );

  modport slave (
    input  addr, wdata, wr_en, rd_en, inst_retired, br_valid, br_taken,
    input  rx_data, rx_valid, tx_ready,
    output rdata, rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/mmio_io_ctrl.sv
// MMIO window with buffered UART RX/TX FIFOs and cycle/instret counters.
// Define BRANCH_STATS_EN to add the branch-resolved/branch-taken counter pair at 0x1C/0x20.
module mmio_io_ctrl #(
  parameter int          RX_DEPTH  = 8,
  parameter int          TX_DEPTH  = 8,
  parameter int          CNT_W     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic         clk,
  input  logic         rst,
  mmio_io_ctrl_if.slave bus
);
  localparam int RX_PW = $clog2(RX_DEPTH);
  localparam int TX_PW = $clog2(TX_DEPTH);
  localparam logic [RX_PW:0] RX_CAP = (RX_PW+1)'(RX_DEPTH);
  localparam logic [TX_PW:0] TX_CAP = (TX_PW+1)'(TX_DEPTH);

  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_RX     = 8'h04;
  localparam logic [7:0] OFF_TX     = 8'h08;
  localparam logic [7:0] OFF_CYC    = 8'h10;
  localparam logic [7:0] OFF_INST   = 8'h14;
  localparam logic [7:0] OFF_CLR    = 8'h18;
  localparam logic [7:0] OFF_BR     = 8'h1C;
  localparam logic [7:0] OFF_BRT    = 8'h20;

  function automatic logic [31:0] zext(input logic [CNT_W-1:0] v);
    zext = '0;
    zext[CNT_W-1:0] = v;
  endfunction

  logic       hit;
  logic [7:0] off;
  logic       rd_hit;
  logic       wr_hit;
  logic       clr;

  assign hit    = (bus.addr[31:8] == BASE_ADDR[31:8]);
  assign off    = bus.addr[7:0];
  assign rd_hit = bus.rd_en & hit;
  assign wr_hit = bus.wr_en & hit;
  assign clr    = wr_hit & (off == OFF_CLR);

  // RX FIFO
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_PW-1:0] rx_wptr;
  logic [RX_PW-1:0] rx_rptr;
  logic [RX_PW:0]   rx_cnt;
  logic             rx_full;
  logic             rx_empty;
  logic             rx_push;
  logic             rx_pop;
  logic [7:0]       rx_head;

  assign rx_full     = (rx_cnt == RX_CAP);
  assign rx_empty    = (rx_cnt == '0);
  assign rx_push     = bus.rx_valid & ~rx_full;
  assign rx_pop      = rd_hit & (off == OFF_RX) & ~rx_empty;
  assign rx_head     = rx_mem[rx_rptr];
  assign bus.rx_ready = ~rx_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wptr <= '0;
      rx_rptr <= '0;
      rx_cnt  <= '0;
      for (int i = 0; i < RX_DEPTH; i++) rx_mem[i] <= '0;
    end else begin
      if (rx_push) begin
        rx_mem[rx_wptr] <= bus.rx_data;
        rx_wptr         <= rx_wptr + RX_PW'(1);
      end
      if (rx_pop) rx_rptr <= rx_rptr + RX_PW'(1);
      if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + (RX_PW+1)'(1);
      else if (rx_pop && !rx_push) rx_cnt <= rx_cnt - (RX_PW+1)'(1);
    end
  end

  // TX FIFO: fullness is judged on the count at the start of the cycle, so a
  // write into a full FIFO is lost even when the transmitter drains a byte.
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_PW-1:0] tx_wptr;
  logic [TX_PW-1:0] tx_rptr;
  logic [TX_PW:0]   tx_cnt;
  logic             tx_full;
  logic             tx_empty;
  logic             tx_push;
  logic             tx_pop;

  assign tx_full      = (tx_cnt == TX_CAP);
  assign tx_empty     = (tx_cnt == '0);
  assign tx_push      = wr_hit & (off == OFF_TX) & ~tx_full;
  assign tx_pop       = ~tx_empty & bus.tx_ready;
  assign bus.tx_valid = ~tx_empty;
  assign bus.tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
      tx_cnt  <= '0;
      for (int i = 0; i < TX_DEPTH; i++) tx_mem[i] <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wptr] <= bus.wdata[7:0];
        tx_wptr         <= tx_wptr + TX_PW'(1);
      end
      if (tx_pop) tx_rptr <= tx_rptr + TX_PW'(1);
      if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + (TX_PW+1)'(1);
      else if (tx_pop && !tx_push) tx_cnt <= tx_cnt - (TX_PW+1)'(1);
    end
  end

  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] inst_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt  <= '0;
      inst_cnt <= '0;
    end else if (clr) begin
      cyc_cnt  <= '0;
      inst_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + CNT_W'(1);
      if (bus.inst_retired) inst_cnt <= inst_cnt + CNT_W'(1);
    end
  end

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] brt_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt  <= '0;
      brt_cnt <= '0;
    end else if (clr) begin
      br_cnt  <= '0;
      brt_cnt <= '0;
    end else if (bus.br_valid) begin
      br_cnt <= br_cnt + CNT_W'(1);
      if (bus.br_taken) brt_cnt <= brt_cnt + CNT_W'(1);
    end
  end
`else
  logic br_unused;
  assign br_unused = bus.br_valid | bus.br_taken;
`endif

  logic wdata_unused;
  assign wdata_unused = ^bus.wdata[31:8];

  // Read mux sees pre-cycle state, so a same-cycle write never affects the load.
  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_STATUS: rd_mux = {30'd0, ~rx_empty, ~tx_full};
      OFF_RX:     rd_mux = rx_empty ? 32'd0 : {24'd0, rx_head};
      OFF_CYC:    rd_mux = zext(cyc_cnt);
      OFF_INST:   rd_mux = zext(inst_cnt);
`ifdef BRANCH_STATS_EN
      OFF_BR:     rd_mux = zext(br_cnt);
      OFF_BRT:    rd_mux = zext(brt_cnt);
`endif
      default:    rd_mux = '0;
    endcase
  end

  logic [31:0] rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rdata_q <= '0;
    else if (rd_hit) rdata_q <= rd_mux;
  end

  assign bus.rdata = rdata_q;

  localparam logic [7:0] OFF_UNUSED_BR = OFF_BR ^ OFF_BRT;
  logic off_br_unused;
  assign off_br_unused = ^OFF_UNUSED_BR;
endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Randomized scoreboard bench for mmio_io_ctrl against a queue-based model of the register map.
module tb_mmio_io_ctrl;
  localparam int          RX_DEPTH = 8;
  localparam int          TX_DEPTH = 8;
  localparam int          CNT_W    = 32;
  localparam logic [31:0] BASE     = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mmio_io_ctrl_if bus();

  mmio_io_ctrl #(
    .RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH), .CNT_W(CNT_W), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  tx_exp_q[$];

  logic [7:0]       rx_m[$];
  logic [7:0]       tx_m[$];
  logic [CNT_W-1:0] m_cyc, m_inst, m_br, m_brt;
  logic [31:0]      m_rdata;
  bit               rd_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] reg_addr(input logic [7:0] o);
    reg_addr = BASE | {24'd0, o};
  endfunction

  // One clock of the register map, computed from the current inputs and model state.
  task automatic model_cycle();
    logic [31:0] v;
    logic [7:0]  o;
    bit in_win, clr, rx_do_pop, rx_do_push, tx_do_push, tx_do_pop;
    in_win = (bus.addr[31:8] == BASE[31:8]);
    o      = bus.addr[7:0];
    rx_do_pop = 1'b0;
    if (bus.rd_en) begin
      v = m_rdata;
      if (in_win) begin
        v = 32'd0;
        case (o)
          8'h00: v = {30'd0, rx_m.size() != 0, tx_m.size() < TX_DEPTH};
          8'h04: if (rx_m.size() != 0) begin
                   v = {24'd0, rx_m[0]};
                   rx_do_pop = 1'b1;
                 end
          8'h10: v = 32'(m_cyc);
          8'h14: v = 32'(m_inst);
`ifdef BRANCH_STATS_EN
          8'h1c: v = 32'(m_br);
          8'h20: v = 32'(m_brt);
`endif
          default: v = 32'd0;
        endcase
      end
      exp_q.push_back(v);
      m_rdata = v;
    end
    rx_do_push = bus.rx_valid && (rx_m.size() < RX_DEPTH);
    tx_do_push = bus.wr_en && in_win && (o == 8'h08) && (tx_m.size() < TX_DEPTH);
    tx_do_pop  = bus.tx_ready && (tx_m.size() != 0);
    clr        = bus.wr_en && in_win && (o == 8'h18);
    if (rx_do_pop)  void'(rx_m.pop_front());
    if (rx_do_push) rx_m.push_back(bus.rx_data);
    if (tx_do_pop)  void'(tx_m.pop_front());
    if (tx_do_push) begin
      tx_m.push_back(bus.wdata[7:0]);
      tx_exp_q.push_back(bus.wdata[7:0]);
    end
    if (clr) begin
      m_cyc = '0; m_inst = '0; m_br = '0; m_brt = '0;
    end else begin
      m_cyc = m_cyc + 1'b1;
      if (bus.inst_retired) m_inst = m_inst + 1'b1;
      if (bus.br_valid) begin
        m_br = m_br + 1'b1;
        if (bus.br_taken) m_brt = m_brt + 1'b1;
      end
    end
  endtask

  // Drive one cycle; pulse inputs set by the caller are dropped after the edge.
  task automatic step(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bus.rd_en = rd;
    bus.wr_en = wr;
    bus.addr  = a;
    bus.wdata = d;
    check("rx_ready", {31'd0, bus.rx_ready}, {31'd0, rx_m.size() < RX_DEPTH});
    check("tx_valid", {31'd0, bus.tx_valid}, {31'd0, tx_m.size() != 0});
    model_cycle();
    @(posedge clk);
    #1;
    bus.rd_en        = 1'b0;
    bus.wr_en        = 1'b0;
    bus.rx_valid     = 1'b0;
    bus.inst_retired = 1'b0;
    bus.br_valid     = 1'b0;
    bus.br_taken     = 1'b0;
  endtask

  task automatic rd(input logic [7:0] o);
    step(1'b1, 1'b0, reg_addr(o), 32'd0);
  endtask

  task automatic wr(input logic [7:0] o, input logic [31:0] d);
    step(1'b0, 1'b1, reg_addr(o), d);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, reg_addr(8'h00), 32'd0);
  endtask

  task automatic do_reset();
    bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.addr = BASE; bus.wdata = '0;
    bus.rx_valid = 1'b0; bus.rx_data = '0; bus.inst_retired = 1'b0;
    bus.br_valid = 1'b0; bus.br_taken = 1'b0;
    rst = 1'b1;
    rd_prev = 1'b0;
    exp_q.delete(); tx_exp_q.delete(); rx_m.delete(); tx_m.delete();
    m_cyc = '0; m_inst = '0; m_br = '0; m_brt = '0; m_rdata = '0;
    #1;
    check("rst_rdata",    bus.rdata, 32'd0);
    check("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
    check("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("rst_tx_data",  {24'd0, bus.tx_data}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: checks the registered load one edge after each read, and every TX byte handed off.
  initial begin
    forever begin
      @(negedge clk);
      if (rd_prev) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rdata_unexpected: got %h expected no load", bus.rdata);
        end else begin
          check("rdata", bus.rdata, exp_q.pop_front());
        end
      end
      rd_prev = !rst && bus.rd_en;
      if (!rst && bus.tx_valid && bus.tx_ready) begin
        if (tx_exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL tx_unexpected: got %h expected no byte", bus.tx_data);
        end else begin
          check("tx_data", {24'd0, bus.tx_data}, {24'd0, tx_exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    logic [7:0] offs [10] = '{8'h00, 8'h04, 8'h08, 8'h0c, 8'h10, 8'h14, 8'h18, 8'h1c, 8'h20, 8'h24};
    logic [31:0] a;
    logic [7:0]  o;
    bus.tx_ready = 1'b0;
    do_reset();

    // Reset state and empty-FIFO reads
    rd(8'h00); rd(8'h04); rd(8'h00);

    // Two RX bytes read back in order
    bus.rx_valid = 1'b1; bus.rx_data = 8'h41; idle();
    bus.rx_valid = 1'b1; bus.rx_data = 8'h42; idle();
    rd(8'h00); rd(8'h04); rd(8'h00); rd(8'h04); rd(8'h00);

    // Overfill RX with no reads, then drain plus one extra read
    for (int i = 1; i <= RX_DEPTH + 1; i++) begin
      bus.rx_valid = 1'b1; bus.rx_data = 8'(i); idle();
    end
    check("rx_full_ready", {31'd0, bus.rx_ready}, 32'd0);
    for (int i = 0; i <= RX_DEPTH; i++) rd(8'h04);
    rd(8'h00);

    // Overfill TX with the transmitter stalled, then let it drain
    bus.tx_ready = 1'b0;
    for (int i = 0; i <= TX_DEPTH; i++) wr(8'h08, 32'hA0 + 32'(i));
    rd(8'h00);
    bus.tx_ready = 1'b1;
    repeat (TX_DEPTH + 2) idle();
    check("tx_drain_left", 32'(tx_exp_q.size()), 32'd0);

    // Counters: clear, 100 cycles with instructions on alternate cycles
    wr(8'h18, 32'd0);
    for (int i = 0; i < 100; i++) begin
      bus.inst_retired = (i % 2 == 0);
      idle();
    end
    rd(8'h14); rd(8'h10);
    wr(8'h18, 32'hFFFF_FFFF);
    rd(8'h10); rd(8'h14);

    // Branch statistics: 10 resolved, 3 taken
    wr(8'h18, 32'd0);
    for (int i = 0; i < 10; i++) begin
      bus.br_valid = 1'b1; bus.br_taken = (i < 3); idle();
    end
    rd(8'h1c); rd(8'h20);

    // Same-cycle read and write to one address
    step(1'b1, 1'b1, reg_addr(8'h18), 32'd0);
    rd(8'h10);
    bus.tx_ready = 1'b0;
    step(1'b1, 1'b1, reg_addr(8'h08), 32'h5A);
    rd(8'h00);

    // Out-of-window accesses: loads hold rdata, stores are ignored
    rd(8'h14);
    step(1'b1, 1'b0, 32'h8000_0110, 32'd0);
    step(1'b0, 1'b1, 32'h8000_0108, 32'h77);
    step(1'b1, 1'b0, 32'h0000_0010, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      o = offs[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0100 | {24'd0, o};
      else a = reg_addr(o);
      if (o == 8'h18 && $urandom_range(0, 7) != 0) a = reg_addr(8'h08);
      bus.rx_valid     = ($urandom_range(0, 2) == 0);
      bus.rx_data      = 8'($urandom);
      bus.tx_ready     = ($urandom_range(0, 2) == 0);
      bus.inst_retired = $urandom_range(0, 1);
      bus.br_valid     = $urandom_range(0, 1);
      bus.br_taken     = $urandom_range(0, 1);
      step($urandom_range(0, 1), $urandom_range(0, 1), a, $urandom);
    end

    // Reset mid-operation with data queued in both FIFOs and a nonzero load pending
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.rx_valid = 1'b1; bus.rx_data = 8'hC0 + 8'(i); wr(8'h08, 32'hD0 + 32'(i));
    end
    rd(8'h10);
    idle();
    do_reset();
    rd(8'h00); rd(8'h04);

    bus.tx_ready = 1'b1;
    repeat (TX_DEPTH + 2) idle();
    check("final_tx_left",  32'(tx_exp_q.size()), 32'd0);
    check("final_rd_left",  32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
